fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 19 +
 rtl/fetch_pc.sv | 34 +++
 rtl/fetch_unit.sv | 142 ++++++++++++++
 tb/tb_fetch_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types and constants for the instruction fetch unit
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_VALID = 2'd1,
        ST_FLUSH = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_e;

    localparam logic [31:0] INSN_BYTES       = 32'd4;
    localparam logic [31:0] NOP_INSN         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic is_aligned(input logic [1:0] i_low_bits);
        return i_low_bits == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_pc.sv
// rtl/fetch_pc.sv - program counter with increment/redirect select and target alignment check
module fetch_pc
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_inc,
    input  logic        i_redirect,
    input  logic [31:0] i_target,
    output logic [31:0] o_pc,
    output logic        o_misaligned
);

    logic [31:0] r_pc;
    logic        w_target_ok;

    assign w_target_ok  = is_aligned(i_target[1:0]);
    assign o_misaligned = i_redirect & ~w_target_ok;
    assign o_pc         = r_pc;

    // A misaligned target never reaches the PC; the fetch FSM parks in FAULT instead.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc <= RESET_PC;
        end else if (i_redirect && w_target_ok) begin
            r_pc <= i_target;
        end else if (i_inc) begin
            r_pc <= r_pc + INSN_BYTES;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetch FSM with redirect, flush and fault handling
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        iClk,
    input  logic        iRstN,
    output logic        oImemReq,
    output logic [31:0] oImemAddr,
    input  logic        iImemAck,
    input  logic [31:0] iImemData,
    input  logic        iStall,
    input  logic        iRedirect,
    input  logic [31:0] iRedirectPC,
    output logic [31:0] oIR,
    output logic [31:0] oPC,
    output logic        oValid,
    output logic        oFault
);

    fetch_state_e r_state, w_state_next;
    logic [31:0]  r_ir, r_opc, r_flush_addr;
    logic         r_valid, r_fault, r_fault_pend;

    logic [31:0]  w_pc;
    logic         w_misaligned, w_redir_ok;
    logic         w_pc_inc, w_capture, w_flush_capture;
    logic         w_valid_next, w_fault_next, w_fault_pend_next;

    fetch_pc #(.RESET_PC(RESET_PC)) u_pc (
        .i_clk        (iClk),
        .i_rst_n      (iRstN),
        .i_inc        (w_pc_inc),
        .i_redirect   (iRedirect),
        .i_target     (iRedirectPC),
        .o_pc         (w_pc),
        .o_misaligned (w_misaligned)
    );

    assign w_redir_ok = iRedirect & ~w_misaligned;

    always_comb begin
        w_state_next      = r_state;
        w_pc_inc          = 1'b0;
        w_capture         = 1'b0;
        w_flush_capture   = 1'b0;
        w_valid_next      = r_valid;
        w_fault_next      = r_fault;
        w_fault_pend_next = r_fault_pend;
        case (r_state)
            ST_REQ: begin
                if (w_misaligned) begin
                    w_fault_next = 1'b1;
                    w_valid_next = 1'b0;
                    if (iImemAck) begin
                        w_state_next = ST_FAULT;
                    end else begin
                        w_state_next      = ST_FLUSH;
                        w_fault_pend_next = 1'b1;
                        w_flush_capture   = 1'b1;
                    end
                end else if (w_redir_ok) begin
                    w_valid_next = 1'b0;
                    if (!iImemAck) begin
                        w_state_next      = ST_FLUSH;
                        w_fault_pend_next = 1'b0;
                        w_flush_capture   = 1'b1;
                    end
                end else if (iImemAck) begin
                    w_capture    = 1'b1;
                    w_pc_inc     = 1'b1;
                    w_valid_next = 1'b1;
                    w_state_next = ST_VALID;
                end
            end
            ST_VALID: begin
                if (w_misaligned) begin
                    w_fault_next = 1'b1;
                    w_valid_next = 1'b0;
                    w_state_next = ST_FAULT;
                end else if (w_redir_ok || !iStall) begin
                    w_valid_next = 1'b0;
                    w_state_next = ST_REQ;
                end
            end
            ST_FLUSH: begin
                // The newest redirect decides whether the flush ends in REQ or FAULT.
                if (w_misaligned) begin
                    w_fault_next      = 1'b1;
                    w_fault_pend_next = 1'b1;
                end else if (w_redir_ok) begin
                    w_fault_next      = 1'b0;
                    w_fault_pend_next = 1'b0;
                end
                if (iImemAck) begin
                    w_state_next = w_fault_pend_next ? ST_FAULT : ST_REQ;
                end
            end
            ST_FAULT: begin
                if (w_redir_ok) begin
                    w_fault_next = 1'b0;
                    w_state_next = ST_REQ;
                end
            end
            default: w_state_next = ST_REQ;
        endcase
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_state      <= ST_REQ;
            r_ir         <= NOP_INSN;
            r_opc        <= RESET_PC;
            r_flush_addr <= RESET_PC;
            r_valid      <= 1'b0;
            r_fault      <= 1'b0;
            r_fault_pend <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_valid      <= w_valid_next;
            r_fault      <= w_fault_next;
            r_fault_pend <= w_fault_pend_next;
            if (w_capture) begin
                r_ir  <= iImemData;
                r_opc <= w_pc;
            end
            if (w_flush_capture) begin
                r_flush_addr <= w_pc;
            end
        end
    end

    // Gating with reset keeps the request low while reset is held even though the state is REQ.
    assign oImemReq  = iRstN & ((r_state == ST_REQ) | (r_state == ST_FLUSH));
    assign oImemAddr = (r_state == ST_FLUSH) ? r_flush_addr : w_pc;
    assign oIR       = r_ir;
    assign oPC       = r_opc;
    assign oValid    = r_valid;
    assign oFault    = r_fault;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        iClk = 1'b0;
    logic        iRstN = 1'b1;
    logic        oImemReq;
    logic [31:0] oImemAddr;
    logic        iImemAck = 1'b0;
    logic [31:0] iImemData;
    logic        iStall = 1'b0;
    logic        iRedirect = 1'b0;
    logic [31:0] iRedirectPC = 32'h0;
    logic [31:0] oIR;
    logic [31:0] oPC;
    logic        oValid;
    logic        oFault;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_unit dut (
        .iClk        (iClk),
        .iRstN       (iRstN),
        .oImemReq    (oImemReq),
        .oImemAddr   (oImemAddr),
        .iImemAck    (iImemAck),
        .iImemData   (iImemData),
        .iStall      (iStall),
        .iRedirect   (iRedirect),
        .iRedirectPC (iRedirectPC),
        .oIR         (oIR),
        .oPC         (oPC),
        .oValid      (oValid),
        .oFault      (oFault)
    );

    always #5 iClk = ~iClk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    assign iImemData = mem_word(oImemAddr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge iClk);
        #1;
    endtask

    initial begin
        // reset state
        #2 iRstN = 1'b0;
        #1;
        check("rst_req",   {31'b0, oImemReq}, 32'd0);
        check("rst_valid", {31'b0, oValid},   32'd0);
        check("rst_fault", {31'b0, oFault},   32'd0);
        check("rst_pc",    oPC,               32'h0000_0000);
        check("rst_ir",    oIR,               32'h0000_0013);
        tick();
        tick();
        iRstN = 1'b1;
        #1;
        check("first_req",  {31'b0, oImemReq}, 32'd1);
        check("first_addr", oImemAddr,         32'h0000_0000);

        // streaming with ack every cycle
        iImemAck = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("seq_req_addr", oImemAddr, 32'(4 * i));
            check("seq_req",      {31'b0, oImemReq}, 32'd1);
            tick();
            check("seq_valid", {31'b0, oValid}, 32'd1);
            check("seq_pc",    oPC, 32'(4 * i));
            check("seq_ir",    oIR, mem_word(32'(4 * i)));
            check("seq_noreq", {31'b0, oImemReq}, 32'd0);
            tick();
            check("seq_gap", {31'b0, oValid}, 32'd0);
        end

        // stall held for three cycles in VALID
        iStall = 1'b1;
        tick();
        iImemAck = 1'b0;
        check("stall_enter_pc", oPC, 32'h10);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_valid", {31'b0, oValid},   32'd1);
            check("stall_pc",    oPC,               32'h10);
            check("stall_ir",    oIR,               mem_word(32'h10));
            check("stall_noreq", {31'b0, oImemReq}, 32'd0);
        end
        iStall = 1'b0;
        tick();
        check("post_stall_req",  {31'b0, oImemReq}, 32'd1);
        check("post_stall_addr", oImemAddr,         32'h14);

        // redirect while the request waits for a delayed ack
        iRedirect = 1'b1;
        iRedirectPC = 32'h100;
        tick();
        iRedirect = 1'b0;
        check("flush_req",  {31'b0, oImemReq}, 32'd1);
        check("flush_addr", oImemAddr,         32'h14);
        tick();
        check("flush_hold_addr", oImemAddr,       32'h14);
        check("flush_valid",     {31'b0, oValid}, 32'd0);
        iImemAck = 1'b1;
        tick();
        check("flush_discard_valid", {31'b0, oValid}, 32'd0);
        check("flush_discard_ir",    oIR,             mem_word(32'h10));
        check("flush_new_addr",      oImemAddr,       32'h100);
        tick();
        check("redir_valid", {31'b0, oValid}, 32'd1);
        check("redir_pc",    oPC,             32'h100);
        check("redir_ir",    oIR,             mem_word(32'h100));
        iImemAck = 1'b0;
        tick();
        check("redir_next_addr", oImemAddr, 32'h104);

        // redirect coincident with ack
        iImemAck = 1'b1;
        iRedirect = 1'b1;
        iRedirectPC = 32'h200;
        tick();
        iRedirect = 1'b0;
        check("coinc_valid", {31'b0, oValid}, 32'd0);
        check("coinc_ir",    oIR,             mem_word(32'h100));
        check("coinc_addr",  oImemAddr,       32'h200);
        tick();
        check("coinc_pc", oPC, 32'h200);
        check("coinc_ir2", oIR, mem_word(32'h200));
        iImemAck = 1'b0;
        tick();
        check("coinc_next_addr", oImemAddr, 32'h204);

        // misaligned redirect with a request outstanding, then recovery
        iRedirect = 1'b1;
        iRedirectPC = 32'h102;
        tick();
        iRedirect = 1'b0;
        check("fault_set",        {31'b0, oFault},   32'd1);
        check("fault_flush_req",  {31'b0, oImemReq}, 32'd1);
        check("fault_flush_addr", oImemAddr,         32'h204);
        iImemAck = 1'b1;
        tick();
        check("fault_noreq", {31'b0, oImemReq}, 32'd0);
        tick();
        check("fault_ack_ignored_req",   {31'b0, oImemReq}, 32'd0);
        check("fault_ack_ignored_valid", {31'b0, oValid},   32'd0);
        check("fault_hold",              {31'b0, oFault},   32'd1);
        iImemAck = 1'b0;
        iRedirect = 1'b1;
        iRedirectPC = 32'h300;
        tick();
        iRedirect = 1'b0;
        check("fault_clear", {31'b0, oFault},   32'd0);
        check("recov_req",   {31'b0, oImemReq}, 32'd1);
        check("recov_addr",  oImemAddr,         32'h300);
        iImemAck = 1'b1;
        tick();
        check("recov_pc", oPC, 32'h300);

        // address wrap at the top of memory
        iImemAck = 1'b0;
        tick();
        iImemAck = 1'b1;
        iRedirect = 1'b1;
        iRedirectPC = 32'hFFFF_FFFC;
        tick();
        iRedirect = 1'b0;
        check("wrap_addr", oImemAddr, 32'hFFFF_FFFC);
        tick();
        check("wrap_pc", oPC, 32'hFFFF_FFFC);
        check("wrap_ir", oIR, mem_word(32'hFFFF_FFFC));
        iImemAck = 1'b0;
        tick();
        check("wrap_next_addr", oImemAddr, 32'h0000_0000);
        check("wrap_req",       {31'b0, oImemReq}, 32'd1);

        // asynchronous reset in the middle of a request
        #2 iRstN = 1'b0;
        #1;
        check("mid_rst_req",   {31'b0, oImemReq}, 32'd0);
        check("mid_rst_valid", {31'b0, oValid},   32'd0);
        check("mid_rst_pc",    oPC,               32'h0000_0000);
        check("mid_rst_ir",    oIR,               32'h0000_0013);
        iImemAck = 1'b1;
        tick();
        check("mid_rst_late_ack", {31'b0, oValid}, 32'd0);
        iImemAck = 1'b0;
        iRstN = 1'b1;
        #1;
        check("mid_rst_restart_addr", oImemAddr,         32'h0000_0000);
        check("mid_rst_restart_req",  {31'b0, oImemReq}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
